// File: rtl/fan_speed_ctrl_if.sv
// Control/status bundle between the thermal controller and its sampling master.
interface fan_speed_ctrl_if;
  logic       enable;
  logic       temp_valid;
  logic [6:0] temperature;
  logic [6:0] setpoint;
  logic [1:0] fan_speed;
  logic       sign;
  logic [6:0] rollover_val;
  logic       alarm;
  logic       busy;

  modport master (
    output enable, temp_valid, temperature, setpoint,
    input  fan_speed, sign, rollover_val, alarm, busy
  );

  modport slave (
    input  enable, temp_valid, temperature, setpoint,
    output fan_speed, sign, rollover_val, alarm, busy
  );
endinterface

// File: rtl/fan_speed_ctrl.sv
// Closed-loop fan/thermal controller: debounced heat/cool requests, reversal hold, fault override.
//
// state | meaning
// IDLE  | controller disabled, fan off, rollover 0
// HOLD  | within dead-band or pausing between heat/cool reversal
// HEAT  | driving temperature up toward setpoint
// COOL  | driving temperature down toward setpoint
// FAULT | over-temperature, fan forced to full, alarm raised
module fan_speed_ctrl #(
  parameter int HYST     = 2,
  parameter int SETTLE   = 3,
  parameter int MAX_TEMP = 100
) (
  input logic             clk_i,
  input logic             rst_i,
  fan_speed_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_HEAT,
    ST_COOL,
    ST_FAULT
  } state_e;

  localparam int CW = (SETTLE <= 3) ? 2 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
  localparam logic [6:0]    H1       = 7'(HYST);
  localparam logic [6:0]    H2       = 7'(2 * HYST);
  localparam logic [6:0]    H4       = 7'(4 * HYST);
  localparam logic [6:0]    TMAX     = 7'(MAX_TEMP);

  state_e        state_q, state_d;
  state_e        pend_state_q, pend_state_d;
  logic [1:0]    pend_speed_q, pend_speed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [1:0]    speed_q, speed_d;
  logic [1:0]    dir_speed;
  logic          sign_q, sign_d;
  logic [6:0]    roll_q, roll_d;
  logic          alarm_q, busy_q;

  logic signed [7:0] err;
  logic [6:0]        mag;
  state_e            req_state;
  logic [1:0]        req_speed;
  logic              fault_hit;

  assign err = $signed({1'b0, bus.temperature}) - $signed({1'b0, bus.setpoint});
  assign mag = err[7] ? 7'(-err) : err[6:0];
  assign fault_hit = bus.temp_valid && (bus.temperature >= TMAX);

  // Band code is mirrored between heat and cool to match the counter stage rate map.
  always_comb begin
    req_state = ST_HOLD;
    req_speed = 2'b00;
    if (mag > H1) begin
      req_state = err[7] ? ST_HEAT : ST_COOL;
      if (mag <= H2)      req_speed = err[7] ? 2'b11 : 2'b01;
      else if (mag <= H4) req_speed = 2'b10;
      else                req_speed = err[7] ? 2'b01 : 2'b11;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_state_d = pend_state_q;
    pend_speed_d = pend_speed_q;
    cnt_d        = cnt_q;
    cnt_inc      = cnt_q;
    dir_speed    = speed_q;

    if (fault_hit) begin
      state_d = ST_FAULT;
      cnt_d   = '0;
    end else if (state_q == ST_FAULT) begin
      if (bus.temp_valid && (bus.temperature <= bus.setpoint))
        state_d = bus.enable ? ST_HOLD : ST_IDLE;
    end else if (!bus.enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_HOLD;
    end else if (bus.temp_valid) begin
      if (req_state == state_q && req_speed == speed_q) begin
        cnt_d = '0;
      end else begin
        if (req_state == pend_state_q && req_speed == pend_speed_q) begin
          cnt_inc = cnt_q + 1'b1;
        end else begin
          pend_state_d = req_state;
          pend_speed_d = req_speed;
          cnt_inc      = CW'(1);
        end
        if (cnt_inc >= SETTLE_C) begin
          cnt_d     = '0;
          dir_speed = req_speed;
          // A direct heat<->cool flip parks in HOLD; the new direction must settle again.
          if ((req_state == ST_HEAT && state_q == ST_COOL) ||
              (req_state == ST_COOL && state_q == ST_HEAT))
            state_d = ST_HOLD;
          else
            state_d = req_state;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    end
  end

  always_comb begin
    speed_d = 2'b00;
    sign_d  = sign_q;
    roll_d  = bus.setpoint;
    case (state_d)
      ST_IDLE: begin
        sign_d = 1'b0;
        roll_d = 7'd0;
      end
      ST_HEAT: begin
        speed_d = dir_speed;
        sign_d  = 1'b1;
      end
      ST_COOL: begin
        speed_d = dir_speed;
        sign_d  = 1'b0;
      end
      ST_FAULT: begin
        speed_d = 2'b11;
        sign_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      pend_state_q <= ST_IDLE;
      pend_speed_q <= 2'b00;
      cnt_q        <= '0;
      speed_q      <= 2'b00;
      sign_q       <= 1'b0;
      roll_q       <= 7'd0;
      alarm_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_state_q <= pend_state_d;
      pend_speed_q <= pend_speed_d;
      cnt_q        <= cnt_d;
      speed_q      <= speed_d;
      sign_q       <= sign_d;
      roll_q       <= roll_d;
      alarm_q      <= (state_d == ST_FAULT);
      busy_q       <= (cnt_d != '0);
    end
  end

  assign bus.fan_speed    = speed_q;
  assign bus.sign         = sign_q;
  assign bus.rollover_val = roll_q;
  assign bus.alarm        = alarm_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Directed bench for fan_speed_ctrl with default HYST=2, SETTLE=3, MAX_TEMP=100.
module tb_fan_speed_ctrl;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  fan_speed_ctrl_if bus ();

  fan_speed_ctrl dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
    end
  endtask

  // One-cycle strobe; returns on the following falling edge with outputs settled.
  task automatic strobe(input logic [6:0] t);
    @(negedge clk_i);
    bus.temperature = t;
    bus.temp_valid  = 1'b1;
    @(negedge clk_i);
    bus.temp_valid  = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] fan, input logic sgn,
                         input logic [6:0] roll, input logic alm, input logic bsy);
    chk({tag, ".fan"},   32'(bus.fan_speed),    32'(fan));
    chk({tag, ".sign"},  32'(bus.sign),         32'(sgn));
    chk({tag, ".roll"},  32'(bus.rollover_val), 32'(roll));
    chk({tag, ".alarm"}, 32'(bus.alarm),        32'(alm));
    chk({tag, ".busy"},  32'(bus.busy),         32'(bsy));
  endtask

  initial begin
    bus.enable      = 1'b0;
    bus.temp_valid  = 1'b0;
    bus.temperature = 7'd0;
    bus.setpoint    = 7'd50;
    repeat (3) @(negedge clk_i);
    chk_out("reset", 2'b00, 1'b0, 7'd0, 1'b0, 1'b0);
    rst_i = 1'b0;

    bus.enable = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk_out("enable_hold", 2'b00, 1'b0, 7'd50, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      strobe(7'd50);
      chk_out("hold50", 2'b00, 1'b0, 7'd50, 1'b0, 1'b0);
    end

    // err=-10 -> far heat, code 01
    strobe(7'd40);
    chk_out("heat_s1", 2'b00, 1'b0, 7'd50, 1'b0, 1'b1);
    strobe(7'd40);
    chk_out("heat_s2", 2'b00, 1'b0, 7'd50, 1'b0, 1'b1);
    strobe(7'd40);
    chk_out("heat_s3", 2'b01, 1'b1, 7'd50, 1'b0, 1'b0);

    strobe(7'd60);
    chk_out("rev_s1", 2'b01, 1'b1, 7'd50, 1'b0, 1'b1);
    strobe(7'd60);
    chk_out("rev_s2", 2'b01, 1'b1, 7'd50, 1'b0, 1'b1);
    strobe(7'd60);
    chk_out("rev_hold", 2'b00, 1'b1, 7'd50, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      strobe((i % 2 == 0) ? 7'd46 : 7'd55);
      chk_out("alternate", 2'b00, 1'b1, 7'd50, 1'b0, 1'b1);
    end

    strobe(7'd60);
    chk_out("cool_s1", 2'b00, 1'b1, 7'd50, 1'b0, 1'b1);
    strobe(7'd60);
    chk_out("cool_s2", 2'b00, 1'b1, 7'd50, 1'b0, 1'b1);
    strobe(7'd60);
    chk_out("cool_s3", 2'b11, 1'b0, 7'd50, 1'b0, 1'b0);

    strobe(7'd99);
    chk_out("temp99", 2'b11, 1'b0, 7'd50, 1'b0, 1'b0);
    strobe(7'd100);
    chk_out("fault", 2'b11, 1'b0, 7'd50, 1'b1, 1'b0);
    bus.enable = 1'b0;
    repeat (2) @(negedge clk_i);
    chk_out("fault_en0", 2'b11, 1'b0, 7'd50, 1'b1, 1'b0);
    strobe(7'd49);
    chk_out("fault_exit", 2'b00, 1'b0, 7'd0, 1'b0, 1'b0);

    bus.enable = 1'b1;
    @(negedge clk_i);
    strobe(7'd40);
    strobe(7'd40);
    chk_out("pre_rst", 2'b00, 1'b0, 7'd50, 1'b0, 1'b1);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk_out("mid_rst", 2'b00, 1'b0, 7'd0, 1'b0, 1'b0);
    rst_i = 1'b0;
    @(negedge clk_i);
    strobe(7'd40);
    chk_out("restart_s1", 2'b00, 1'b0, 7'd50, 1'b0, 1'b1);
    strobe(7'd40);
    chk_out("restart_s2", 2'b00, 1'b0, 7'd50, 1'b0, 1'b1);
    strobe(7'd40);
    chk_out("restart_s3", 2'b01, 1'b1, 7'd50, 1'b0, 1'b0);

    // Enable drop coinciding with a strobe: IDLE wins
    @(negedge clk_i);
    bus.enable      = 1'b0;
    bus.temperature = 7'd60;
    bus.temp_valid  = 1'b1;
    @(negedge clk_i);
    bus.temp_valid  = 1'b0;
    chk_out("en_drop", 2'b00, 1'b0, 7'd0, 1'b0, 1'b0);

    bus.enable = 1'b1;
    @(negedge clk_i);
    for (int i = 0; i < 3; i++) begin
      strobe(7'd52);
      chk_out("hyst_edge", 2'b00, 1'b0, 7'd50, 1'b0, 1'b0);
    end
    strobe(7'd53);
    strobe(7'd53);
    chk_out("near_s2", 2'b00, 1'b0, 7'd50, 1'b0, 1'b1);
    strobe(7'd53);
    chk_out("near_cool", 2'b01, 1'b0, 7'd50, 1'b0, 1'b0);

    bus.setpoint = 7'd45;
    repeat (2) @(negedge clk_i);
    chk("roll_track", 32'(bus.rollover_val), 32'd45);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fan_speed_ctrl.md
# fan_speed_ctrl

Closed-loop thermal controller that sits directly downstream of the fan/temperature counter stage. It samples the 7-bit temperature on each counter rollover strobe and compares it against a setpoint. It then drives the `fan_speed`, `sign` and `rollover_val` controls that the counter stage consumes. Speed changes are debounced, heat/cool reversals pass through a hold state, and an over-temperature fault overrides everything.

## Interface
- `HYST`, default 2: dead-band half-width in degrees; |err| ≤ HYST means hold.
- `SETTLE`, default 3: consecutive matching samples required before a new request is applied; must be ≥ 1.
- `MAX_TEMP`, default 100: fault threshold.
- `CLK`  in  1  clock, rising-edge.
- `RST`  in  1  synchronous, active-high reset.
- `enable`  in  1  controller run; low forces IDLE (except from FAULT).
- `temp_valid`  in  1  one-cycle sample strobe, driven from the counter rollover flag.
- `temperature`  in  7  current temperature, unsigned.
- `setpoint`  in  7  target temperature, unsigned, sampled with `temp_valid`.
- `fan_speed`  out  2  speed code to counter stage.
- `sign`  out  1  1 = heat (temperature rises), 0 = cool.
- `rollover_val`  out  7  temperature limit for counter stage.
- `alarm`  out  1  high while in FAULT.
- `busy`  out  1  high while a pending request is settling (count > 0).

## Operation
- States: IDLE, HOLD, HEAT, COOL, FAULT.
- Error: err = temperature − setpoint, computed at 8-bit signed width. mag = |err|, 7-bit.
- Request derived per valid sample:
  - mag ≤ HYST: HOLD.
  - err < 0: HEAT.
  - err > 0: COOL.
- Band:
  - near: HYST < mag ≤ 2·HYST.
  - mid: 2·HYST < mag ≤ 4·HYST.
  - far: mag > 4·HYST.
- Speed encoding matches the counter stage's rate mapping:
  - HEAT: near→2'b11, mid→2'b10, far→2'b01.
  - COOL: near→2'b01, mid→2'b10, far→2'b11.
  - HOLD/IDLE: 2'b00.
- Outputs per state:
  - HEAT: `sign`=1, `rollover_val`=setpoint.
  - COOL: `sign`=0, `rollover_val`=setpoint.
  - HOLD: `sign` keeps its last value, `rollover_val`=setpoint.
  - IDLE: `sign`=0, `rollover_val`=0.
- Debounce: pending register holds {state, speed} plus a 2-bit-or-wider counter.
  - Request equals the applied value: counter clears.
  - Request differs from pending: pending ← request, counter ← 1.
  - Request equals pending: counter increments.
  - Counter reaches SETTLE: request is applied and the counter clears.
- Reversal rule: an applied request of HEAT while in COOL (or the reverse) moves to HOLD instead. The opposite direction then needs a fresh SETTLE run.
- IDLE → HOLD when `enable`=1. Any non-FAULT state → IDLE when `enable`=0; the pending counter clears.
- FAULT entry: any valid sample with temperature ≥ MAX_TEMP, regardless of `enable` or debounce. Entry is immediate.
- In FAULT: `fan_speed`=2'b11, `sign`=0, `rollover_val`=setpoint, `alarm`=1.
- FAULT exit: on a valid sample with temperature ≤ setpoint, go to HOLD, or to IDLE if `enable`=0.
- `temp_valid` low: no state or pending change, apart from the enable-driven IDLE transition.

## Timing
- All outputs registered.
- Reset values: state IDLE, `fan_speed`=0, `sign`=0, `rollover_val`=0, `alarm`=0, `busy`=0, pending counter 0.
- Sample at edge N (`temp_valid`=1) affects outputs after edge N, visible in cycle N+1.
- Minimum latency from a changed request to the output: SETTLE valid samples. With SETTLE=1, one cycle after the strobe.
- Fault: `alarm` and `fan_speed`=2'b11 are visible one cycle after the offending sample.
- Simultaneous events:
  - Fault and `enable` drop: FAULT wins.
  - Enable drop and a valid sample: IDLE wins, and the sample is discarded.
- Reset mid-settle: pending state lost, outputs return to reset values the next cycle.
- Setpoint is used only at valid samples. Changes between strobes have no effect until the next strobe, except that `rollover_val` tracks the setpoint in HEAT/COOL/HOLD/FAULT.

## Test plan
- Reset, then `enable`=1, setpoint=50, temperature=50 strobed 5× → HOLD, `fan_speed`=00, `busy` never set.
- Setpoint=50, temperature=40 strobed 3× → after the 3rd strobe HEAT, `fan_speed`=01, `sign`=1, `rollover_val`=50; after strobes 1–2 outputs unchanged, `busy`=1.
- From HEAT (temperature 40), strobe 60 three times → HOLD (`fan_speed`=00). Three more strobes of 60 → COOL, `fan_speed`=11 (err=10, far).
- Alternating requests 46/55/46 strobed 6× with setpoint 50 → state never leaves HOLD; pending counter re-arms at 1 on each change.
- In COOL, strobe temperature=100 → next cycle `alarm`=1, `fan_speed`=11. Drop `enable`, stay in FAULT. Strobe 49 → IDLE, `alarm`=0.
- Assert `RST` one cycle after the 2nd of 3 settling strobes → all outputs at reset values; a following strobe restarts the count at 1.
